// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolve queue.
//   PC_W_DEF   : default program-counter width
//   CNT_W_DEF  : default statistics counter width
//   INSN_BYTES : fall-through distance to the next sequential fetch PC
//   bp_entry_t : layout of one in-flight prediction at the default PC width.
//                Queue storage packs the same {pc, taken} order at any PC_W.
package bp_pkg;
  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned INSN_BYTES = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                taken;
  } bp_entry_t;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-facing bundle of the branch resolve queue.
//   pred_*         : prediction push from fetch (pred_ready back-pressure)
//   res_*          : resolution of the oldest in-flight branch from execute
//   upd_*          : registered training update to the predictor
//   flush/redirect : one-cycle mispredict pulse with corrected fetch PC
//   count, branch_cnt, mispredict_cnt, res_err : status and statistics
// master = surrounding pipeline, slave = queue.
interface branch_resolve_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            pred_valid;
  logic            pred_taken;
  logic [PC_W-1:0] pred_pc;
  logic            pred_ready;
  logic            res_valid;
  logic            res_taken;
  logic [PC_W-1:0] res_target;
  logic            upd_valid;
  logic            upd_taken;
  logic [PC_W-1:0] upd_pc;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;
  logic [CW-1:0]   count;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;
  logic            res_err;

  modport master (
    output pred_valid, pred_taken, pred_pc, res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_taken, upd_pc, flush, redirect_pc,
           count, branch_cnt, mispredict_cnt, res_err
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_taken, upd_pc, flush, redirect_pc,
           count, branch_cnt, mispredict_cnt, res_err
  );
endinterface

// File: rtl/bp_fifo.sv
// Generic DEPTH x W synchronous FIFO with show-ahead head data.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request (ignored when full or clearing)
//   pop        : read request (ignored when empty)
//   clear      : drop all entries; takes priority over push/pop
//   full, empty, count, head : occupancy status and oldest entry
module bp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       clear,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full && !clear;
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  // Clear empties the queue by snapping the read pointer onto the write
  // pointer; a simultaneous push is discarded so wr_ptr stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions awaiting resolution. On each resolve
// the oldest entry is compared with the actual outcome; the result drives a
// registered predictor training update, a one-cycle flush/redirect on
// mispredict, and saturating branch/mispredict statistics.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : branch_resolve_queue_if slave (pred/res in, upd/flush/status out)
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  branch_resolve_queue_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = PC_W + 1;

  logic [EW-1:0]    w_head;
  logic [PC_W-1:0]  w_head_pc;
  logic             w_head_taken;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_mis;
  logic [PC_W-1:0]  w_redirect;

  logic             r_upd_valid;
  logic             r_upd_taken;
  logic [PC_W-1:0]  r_upd_pc;
  logic             r_flush;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;
  logic             r_res_err;

  // No bypass when full: readiness depends only on registered state.
  assign w_ready      = !w_full && !r_flush;
  assign w_push       = bus.pred_valid && w_ready;
  assign w_pop        = bus.res_valid && !w_empty;
  assign w_head_pc    = w_head[EW-1:1];
  assign w_head_taken = w_head[0];
  assign w_mis        = w_pop && (w_head_taken != bus.res_taken);
  assign w_redirect   = bus.res_taken ? bus.res_target
                                      : w_head_pc + PC_W'(INSN_BYTES);

  // A mispredict makes every younger entry wrong-path, so the pop that
  // detects it also clears the queue.
  bp_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (w_push),
    .din   ({bus.pred_pc, bus.pred_taken}),
    .pop   (w_pop),
    .clear (w_mis),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_upd_valid      <= 1'b0;
      r_upd_taken      <= 1'b0;
      r_upd_pc         <= '0;
      r_flush          <= 1'b0;
      r_redirect_pc    <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
      r_res_err        <= 1'b0;
    end else begin
      r_upd_valid <= w_pop;
      r_flush     <= w_mis;
      if (w_pop) begin
        r_upd_taken <= bus.res_taken;
        r_upd_pc    <= w_head_pc;
        if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      // redirect_pc only moves on a mispredict so it holds while flush=0.
      if (w_mis) begin
        r_redirect_pc <= w_redirect;
        if (r_mispredict_cnt != '1) r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
      end
      if (bus.res_valid && w_empty) r_res_err <= 1'b1;
    end
  end

  assign bus.pred_ready     = w_ready;
  assign bus.upd_valid      = r_upd_valid;
  assign bus.upd_taken      = r_upd_taken;
  assign bus.upd_pc         = r_upd_pc;
  assign bus.flush          = r_flush;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.count          = w_count;
  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.mispredict_cnt = r_mispredict_cnt;
  assign bus.res_err        = r_res_err;
endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_queue_if #(.DEPTH(4), .PC_W(32), .CNT_W(4)) bus ();

  branch_resolve_queue #(.DEPTH(4), .PC_W(32), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic pt, input logic [31:0] pc,
                       input logic rv, input logic rt, input logic [31:0] tgt);
    bus.pred_valid = pv;
    bus.pred_taken = pt;
    bus.pred_pc    = pc;
    bus.res_valid  = rv;
    bus.res_taken  = rt;
    bus.res_target = tgt;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    chk("rst_ready", 32'(bus.pred_ready), 1);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("rst_branch_cnt", 32'(bus.branch_cnt), 0);
    chk("rst_mis_cnt", 32'(bus.mispredict_cnt), 0);
    chk("rst_res_err", 32'(bus.res_err), 0);
    chk("rst_redirect", bus.redirect_pc, 0);
    #3 reset_n = 1'b1;
    cyc();

    // Correct predictions
    drive(1, 1, 32'h100, 0, 0, 0); cyc();
    chk("t1_count1", 32'(bus.count), 1);
    drive(1, 0, 32'h104, 0, 0, 0); cyc();
    chk("t1_count2", 32'(bus.count), 2);
    drive(0, 0, 0, 1, 1, 32'h999); cyc();
    chk("t1_upd_valid_a", 32'(bus.upd_valid), 1);
    chk("t1_upd_pc_a", bus.upd_pc, 32'h100);
    chk("t1_upd_taken_a", 32'(bus.upd_taken), 1);
    chk("t1_flush_a", 32'(bus.flush), 0);
    chk("t1_count_a", 32'(bus.count), 1);
    drive(0, 0, 0, 1, 0, 0); cyc();
    chk("t1_upd_valid_b", 32'(bus.upd_valid), 1);
    chk("t1_upd_pc_b", bus.upd_pc, 32'h104);
    chk("t1_upd_taken_b", 32'(bus.upd_taken), 0);
    chk("t1_flush_b", 32'(bus.flush), 0);
    chk("t1_count_b", 32'(bus.count), 0);
    chk("t1_branch_cnt", 32'(bus.branch_cnt), 2);
    chk("t1_mis_cnt", 32'(bus.mispredict_cnt), 0);
    drive(0, 0, 0, 0, 0, 0); cyc();
    chk("t1_upd_idle", 32'(bus.upd_valid), 0);

    // Mispredict not-taken; concurrent push is discarded
    drive(1, 1, 32'h200, 0, 0, 0); cyc();
    drive(1, 1, 32'h204, 0, 0, 0); cyc();
    drive(1, 0, 32'h208, 0, 0, 0); cyc();
    chk("t2_count3", 32'(bus.count), 3);
    drive(1, 1, 32'h2fc, 1, 0, 32'hdead); cyc();
    chk("t2_flush", 32'(bus.flush), 1);
    chk("t2_redirect", bus.redirect_pc, 32'h204);
    chk("t2_count0", 32'(bus.count), 0);
    chk("t2_mis_cnt", 32'(bus.mispredict_cnt), 1);
    chk("t2_branch_cnt", 32'(bus.branch_cnt), 3);
    chk("t2_ready_flush", 32'(bus.pred_ready), 0);
    chk("t2_upd_pc", bus.upd_pc, 32'h200);
    chk("t2_upd_taken", 32'(bus.upd_taken), 0);
    drive(1, 1, 32'h2f8, 0, 0, 0); cyc();
    chk("t2_flush_pulse", 32'(bus.flush), 0);
    chk("t2_ready_after", 32'(bus.pred_ready), 1);
    chk("t2_push_ignored", 32'(bus.count), 0);
    chk("t2_redirect_hold", bus.redirect_pc, 32'h204);

    // Mispredict taken
    drive(1, 0, 32'h300, 0, 0, 0); cyc();
    chk("t3_count1", 32'(bus.count), 1);
    drive(0, 0, 0, 1, 1, 32'h400); cyc();
    chk("t3_flush", 32'(bus.flush), 1);
    chk("t3_redirect", bus.redirect_pc, 32'h400);
    chk("t3_upd_taken", 32'(bus.upd_taken), 1);
    chk("t3_upd_pc", bus.upd_pc, 32'h300);
    chk("t3_mis_cnt", 32'(bus.mispredict_cnt), 2);
    drive(0, 0, 0, 0, 0, 0); cyc();

    // Full queue: no bypass on simultaneous push/pop
    drive(1, 1, 32'h500, 0, 0, 0); cyc();
    drive(1, 1, 32'h504, 0, 0, 0); cyc();
    drive(1, 1, 32'h508, 0, 0, 0); cyc();
    drive(1, 1, 32'h50c, 0, 0, 0); cyc();
    chk("t4_count4", 32'(bus.count), 4);
    chk("t4_ready_full", 32'(bus.pred_ready), 0);
    drive(1, 1, 32'h510, 1, 1, 0); cyc();
    chk("t4_count3", 32'(bus.count), 3);
    chk("t4_ready", 32'(bus.pred_ready), 1);
    chk("t4_upd_pc0", bus.upd_pc, 32'h500);
    chk("t4_flush", 32'(bus.flush), 0);
    drive(0, 0, 0, 1, 1, 0); cyc();
    chk("t4_upd_pc1", bus.upd_pc, 32'h504);
    cyc();
    chk("t4_upd_pc2", bus.upd_pc, 32'h508);
    cyc();
    chk("t4_upd_pc3", bus.upd_pc, 32'h50c);
    chk("t4_count0", 32'(bus.count), 0);
    chk("t4_branch_cnt", 32'(bus.branch_cnt), 8);

    // Resolve on empty queue
    cyc();
    chk("t5_res_err", 32'(bus.res_err), 1);
    chk("t5_no_upd", 32'(bus.upd_valid), 0);
    chk("t5_branch_cnt", 32'(bus.branch_cnt), 8);
    drive(0, 0, 0, 0, 0, 0); cyc();
    chk("t5_res_err_sticky", 32'(bus.res_err), 1);

    // branch_cnt saturation (CNT_W=4)
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 32'h600 + 32'(i * 4), 0, 0, 0); cyc();
      drive(0, 0, 0, 1, 1, 0); cyc();
      chk("t6_branch_sat", 32'(bus.branch_cnt), (i + 9 > 15) ? 15 : 32'(i + 9));
    end
    chk("t6_mis_cnt", 32'(bus.mispredict_cnt), 2);

    // Async reset with entries queued
    drive(1, 1, 32'h700, 0, 0, 0); cyc();
    drive(1, 0, 32'h704, 0, 0, 0); cyc();
    drive(1, 1, 32'h708, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, 1, 0); cyc();
    chk("t7_count2", 32'(bus.count), 2);
    chk("t7_upd_valid", 32'(bus.upd_valid), 1);
    drive(0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_count", 32'(bus.count), 0);
    chk("t7_upd_valid0", 32'(bus.upd_valid), 0);
    chk("t7_upd_pc", bus.upd_pc, 0);
    chk("t7_branch_cnt", 32'(bus.branch_cnt), 0);
    chk("t7_mis_cnt", 32'(bus.mispredict_cnt), 0);
    chk("t7_res_err", 32'(bus.res_err), 0);
    chk("t7_redirect", bus.redirect_pc, 0);
    chk("t7_ready", 32'(bus.pred_ready), 1);
    cyc();
    #2 reset_n = 1'b1;
    cyc();
    chk("t7_flush_after", 32'(bus.flush), 0);
    chk("t7_count_after", 32'(bus.count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
Downstream consumer of the 2-bit branch predictor.
- Holds each in-flight prediction (PC and predicted direction) in order, from fetch until execute resolves the branch.
- On resolution, compares the stored prediction against the actual outcome. On a mismatch it raises a one-cycle flush with a redirect PC.
- Every resolved outcome is fed back as a registered training update, which drives the predictor's taken input.
- Keeps saturating branch and mispredict statistics.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
PC_W, 32, program-counter width
CNT_W, 16, statistics counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pred_valid  in  1  fetch presents a prediction
pred_taken  in  1  predicted direction (predictor predict output)
pred_pc  in  PC_W  PC of predicted branch
pred_ready  out  1  queue accepts a push this cycle
res_valid  in  1  execute resolves oldest in-flight branch
res_taken  in  1  actual direction
res_target  in  PC_W  actual taken target
upd_valid  out  1  training update strobe
upd_taken  out  1  actual direction for predictor update
upd_pc  out  PC_W  PC being trained
flush  out  1  one-cycle mispredict pulse
redirect_pc  out  PC_W  correct fetch PC, valid when flush=1
count  out  $clog2(DEPTH)+1  current occupancy
branch_cnt  out  CNT_W  resolved branches, saturating
mispredict_cnt  out  CNT_W  mispredicts, saturating
res_err  out  1  sticky: resolve seen while empty

Behaviour:
- Reset (async assert, sync release):
  - Pointers, count, flush, upd_*, redirect_pc, counters and res_err all clear to 0.
  - pred_ready=1 immediately after reset.
- pred_ready = (count != DEPTH) && !flush. Combinational from state only; no bypass when full, even if a pop occurs the same cycle.
- Push: pred_valid && pred_ready writes {pred_pc, pred_taken} at wr_ptr. wr_ptr advances modulo DEPTH.
- Pop: res_valid && count != 0 reads the entry at rd_ptr. rd_ptr advances modulo DEPTH.
- Mispredict: stored taken != res_taken on a pop.
- Push and pop in the same cycle without mispredict: count unchanged. Both pointers advance.
- Registered outputs, all asserted the cycle after the pop (latency 1):
  - upd_valid=1, upd_taken=res_taken, upd_pc=stored pc.
  - branch_cnt increments, saturating at all-ones.
  - If mispredict: flush=1 and mispredict_cnt increments (saturating).
  - redirect_pc = res_target if res_taken, else stored pc + 4 (wraps modulo 2^PC_W).
- upd_valid, flush: single-cycle pulses; deassert next cycle unless a new pop occurs.
- Queue clear on mispredict:
  - In the pop cycle, all younger entries are wrong-path. Next state: count=0, rd_ptr=wr_ptr.
  - A push in that same cycle is discarded.
- While flush=1: pred_ready=0, pushes ignored, and resolves still processed normally against the (empty) queue.
- res_valid with count=0:
  - No pop, no update, no counter change.
  - res_err sets and holds until reset.
- redirect_pc holds its last value when flush=0.
- Reset mid-operation: all in-flight entries are lost and outputs clear asynchronously; no flush is generated.

Decomposition:
- Shared package bp_pkg:
  - PC_W default
  - INSN_BYTES=4
  - CNT_W
  - entry struct {pc, taken}
- One natural sub-module: bp_fifo, a generic DEPTH×entry synchronous FIFO.
  - Ports: push, pop, clear, full, empty, count, head data.
  - branch_resolve_queue wraps it with the compare, update, flush and statistics logic.

Test Plan:
- Push pc=0x100/T, 0x104/N; resolve T then N -> upd pulses (0x100,1), (0x104,0); flush never asserts; branch_cnt=2; mispredict_cnt=0; count returns to 0.
- Push 0x200/T, 0x204/T, 0x208/N; resolve first with res_taken=0 -> next cycle flush=1, redirect_pc=0x204, count=0, mispredict_cnt=1; the following cycle pred_ready=1.
- Push 0x300/N; resolve res_taken=1, res_target=0x400 -> flush=1, redirect_pc=0x400, upd_taken=1, upd_pc=0x300.
- Fill DEPTH=4 entries -> pred_ready=0; a push plus pop in the same cycle is not accepted; count goes 4 -> 3, then pred_ready=1.
- res_valid on empty queue -> res_err=1 stays high, branch_cnt unchanged, no upd_valid; drop reset_n with 2 entries queued -> all outputs 0 asynchronously, res_err cleared.
- Preload branch_cnt near all-ones via 65535+ correct resolves (or CNT_W=4 override) -> branch_cnt saturates at all-ones and does not wrap.
